alu_wb_buffer: RTL and testbench

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

---
 rtl/ariane_pkg.sv | 14 +
 rtl/config_pkg.sv | 13 +
 rtl/riscv_pkg.sv | 6 +
 rtl/alu_wb_buffer.sv | 114 +++++++++++
 tb/tb_alu_wb_buffer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// Core-wide types and constants.
// alu_wb_entry_t is one buffered ALU result on its way to writeback.
package ariane_pkg;

    // Scoreboard tag width (8-entry scoreboard).
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [riscv::XLEN-1:0]   result;
        logic                     branch_res;
    } alu_wb_entry_t;

endpackage : ariane_pkg

// File: rtl/config_pkg.sv
// Core configuration package.
// Holds the configuration record handed down to core blocks. The empty
// configuration marks "no override": blocks fall back to the
// package-level constants in riscv / ariane_pkg.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;  // 0 = use riscv::XLEN
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd0};

endpackage : config_pkg

// File: rtl/riscv_pkg.sv
// RISC-V architectural constants shared across the core.
package riscv;

    localparam int unsigned XLEN = 64;

endpackage : riscv

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer
// Decouples the ALU from the writeback port with a small circular FIFO of
// results. The head entry is presented on wb_* straight from storage;
// there is no input-to-output bypass.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop every buffered result on the next edge
//   alu_valid_i/ready_o   result input handshake
//   alu_trans_id_i,
//   alu_result_i,
//   alu_branch_res_i      result payload
//   wb_valid_o/ready_i    writeback output handshake
//   wb_trans_id_o,
//   wb_result_o,
//   wb_branch_res_o       head entry payload (undefined while !wb_valid_o)
//   count_o               number of occupied entries
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high and flush_i is low. ready never depends on the same-cycle
// valid of either side, and a producer holds its payload stable while
// valid is high and ready is low.
module alu_wb_buffer
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          alu_valid_i,
    output logic                          alu_ready_o,
    input  logic [TRANS_ID_BITS-1:0]      alu_trans_id_i,
    input  logic [riscv::XLEN-1:0]        alu_result_i,
    input  logic                          alu_branch_res_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]      wb_trans_id_o,
    output logic [riscv::XLEN-1:0]        wb_result_o,
    output logic                          wb_branch_res_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Elaboration-time sanity checks on the parameters.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("alu_wb_buffer: DEPTH must be a power of 2 and at least 2");
    end
    if (CVA6Cfg.XLEN != 0 && CVA6Cfg.XLEN != riscv::XLEN) begin : g_cfg_check
        $error("alu_wb_buffer: CVA6Cfg.XLEN disagrees with riscv::XLEN");
    end

    alu_wb_entry_t              mem [DEPTH];
    alu_wb_entry_t              entry_in;
    alu_wb_entry_t              head;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       push;
    logic                       pop;

    // Ready/valid come only from the registered counter.
    assign alu_ready_o = (count != FULL_CNT);
    assign wb_valid_o  = (count != '0);
    assign count_o     = count;

    assign push = alu_valid_i && alu_ready_o && !flush_i;
    assign pop  = wb_valid_o && wb_ready_i && !flush_i;

    always_comb begin
        entry_in            = '0;
        entry_in.trans_id   = alu_trans_id_i;
        entry_in.result     = alu_result_i;
        entry_in.branch_res = alu_branch_res_i;
    end

    assign head            = mem[rd_ptr];
    assign wb_trans_id_o   = head.trans_id;
    assign wb_result_o     = head.result;
    assign wb_branch_res_o = head.branch_res;

    // Control state. Pointers are PTR_W bits wide, so they wrap modulo
    // DEPTH on their own because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately left out of reset; the counter alone
    // decides which slots hold live data.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= entry_in;
    end

endmodule : alu_wb_buffer

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer (DEPTH = 4). Inputs change and outputs
// are sampled 1 ns after each rising edge.
module tb_alu_wb_buffer;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b0;
    logic                     flush_i = 1'b0;
    logic                     alu_valid_i = 1'b0;
    logic                     alu_ready_o;
    logic [TRANS_ID_BITS-1:0] alu_trans_id_i = '0;
    logic [riscv::XLEN-1:0]   alu_result_i = '0;
    logic                     alu_branch_res_i = 1'b0;
    logic                     wb_valid_o;
    logic                     wb_ready_i = 1'b0;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
    logic [riscv::XLEN-1:0]   wb_result_o;
    logic                     wb_branch_res_o;
    logic [$clog2(DEPTH):0]   count_o;

    int checks = 0;
    int failures = 0;

    // scoreboard of trans ids expected at the head, in push order
    logic [TRANS_ID_BITS-1:0] exp_q[$];

    alu_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .alu_valid_i     (alu_valid_i),
        .alu_ready_o     (alu_ready_o),
        .alu_trans_id_i  (alu_trans_id_i),
        .alu_result_i    (alu_result_i),
        .alu_branch_res_i(alu_branch_res_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_trans_id_o   (wb_trans_id_o),
        .wb_result_o     (wb_result_o),
        .wb_branch_res_o (wb_branch_res_o),
        .count_o         (count_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [riscv::XLEN-1:0] data_of(input int id);
        return riscv::XLEN'(64'h0000_1000_A5A5_0000 + 64'(id));
    endfunction

    // driver: present one result for the next edge (held until changed)
    task automatic drive(input int id, input logic valid);
        alu_valid_i      = valid;
        alu_trans_id_i   = TRANS_ID_BITS'(id);
        alu_result_i     = data_of(id);
        alu_branch_res_i = id[0];
    endtask

    task automatic push_one(input int id);
        drive(id, 1'b1);
        tick();
        drive(0, 1'b0);
    endtask

    initial begin
        // reset
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst_alu_ready", 64'(alu_ready_o), 64'd1);

        // single push, then stalled for 5 cycles
        alu_valid_i = 1'b1;
        alu_trans_id_i = 3'd3;
        alu_result_i = 64'h0000_0000_DEAD_BEEF;
        alu_branch_res_i = 1'b1;
        tick();
        drive(0, 1'b0);
        check("p1_wb_valid", 64'(wb_valid_o), 64'd1);
        check("p1_id", 64'(wb_trans_id_o), 64'd3);
        check("p1_result", 64'(wb_result_o), 64'h0000_0000_DEAD_BEEF);
        check("p1_branch", 64'(wb_branch_res_o), 64'd1);
        check("p1_count", 64'(count_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(wb_valid_o), 64'd1);
            check("stall_id", 64'(wb_trans_id_o), 64'd3);
            check("stall_result", 64'(wb_result_o), 64'h0000_0000_DEAD_BEEF);
            check("stall_branch", 64'(wb_branch_res_o), 64'd1);
        end
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        check("p1_drain_count", 64'(count_o), 64'd0);
        check("p1_drain_valid", 64'(wb_valid_o), 64'd0);

        // fill: ids 0..4 back-to-back, id 4 must be refused
        for (int i = 0; i < 5; i++) begin
            drive(i, 1'b1);
            check("fill_ready", 64'(alu_ready_o), (i < DEPTH) ? 64'd1 : 64'd0);
            tick();
        end
        drive(0, 1'b0);
        check("full_count", 64'(count_o), 64'd4);
        check("full_ready", 64'(alu_ready_o), 64'd0);

        // drain in order
        wb_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 64'(wb_valid_o), 64'd1);
            check("drain_id", 64'(wb_trans_id_o), 64'(i));
            check("drain_result", 64'(wb_result_o), 64'(data_of(i)));
            check("drain_branch", 64'(wb_branch_res_o), 64'(i % 2));
            tick();
        end
        wb_ready_i = 1'b0;
        check("drain_count", 64'(count_o), 64'd0);
        check("drain_ready", 64'(alu_ready_o), 64'd1);
        check("drain_wb_valid", 64'(wb_valid_o), 64'd0);

        // streaming at count 1 for 10 cycles (pointers wrap twice)
        push_one(5);
        exp_q.push_back(3'd5);
        check("stream_start_count", 64'(count_o), 64'd1);
        wb_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive((6 + i) % 8, 1'b1);
            exp_q.push_back(TRANS_ID_BITS'((6 + i) % 8));
            check("stream_valid", 64'(wb_valid_o), 64'd1);
            check("stream_id", 64'(wb_trans_id_o), 64'(exp_q.pop_front()));
            tick();
            check("stream_count", 64'(count_o), 64'd1);
        end
        drive(0, 1'b0);
        check("stream_last_id", 64'(wb_trans_id_o), 64'(exp_q.pop_front()));
        tick();
        wb_ready_i = 1'b0;
        check("stream_end_count", 64'(count_o), 64'd0);

        // flush at count 3 with a simultaneous push
        push_one(1);
        push_one(2);
        push_one(3);
        check("pre_flush_count", 64'(count_o), 64'd3);
        flush_i = 1'b1;
        drive(7, 1'b1);
        tick();
        flush_i = 1'b0;
        drive(0, 1'b0);
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
        tick();
        check("flush_discard_count", 64'(count_o), 64'd0);
        push_one(4);
        check("post_flush_count", 64'(count_o), 64'd1);
        check("post_flush_id", 64'(wb_trans_id_o), 64'd4);
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;

        // reset and flush together on a full buffer, with a pop requested
        for (int i = 0; i < 4; i++) push_one(i + 2);
        check("rf_full_count", 64'(count_o), 64'd4);
        rst_i = 1'b1;
        flush_i = 1'b1;
        wb_ready_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flush_i = 1'b0;
        wb_ready_i = 1'b0;
        check("rf_count", 64'(count_o), 64'd0);
        check("rf_alu_ready", 64'(alu_ready_o), 64'd1);
        check("rf_wb_valid", 64'(wb_valid_o), 64'd0);
        push_one(6);
        check("rf_post_id", 64'(wb_trans_id_o), 64'd6);
        check("rf_post_result", 64'(wb_result_o), 64'(data_of(6)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_wb_buffer
